spi_slave_responder: RTL and testbench

//  Peripheral (slave) end of the 3/4-wire SPI link used by the light-sensor and SD masters.

---
 rtl/spi_slave_responder.sv | 140 ++++++++++++++
 tb/tb_spi_slave_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder.sv
// SPI mode-0 peripheral: oversamples SCK/CS/MOSI, shifts tx word out on MISO, captures MOSI word.
// Edges act 3 clk_i cycles after the pin transition; all outputs are registered.
module spi_slave_responder #(
    parameter int   N_BITS    = 16,
    parameter logic IDLE_MISO = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sck_i,
    input  logic              cs_i,
    input  logic              mosi_i,
    input  logic [N_BITS-1:0] tx_data_i,
    output logic              miso_o,
    output logic [N_BITS-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o,
    output logic              frame_err_o
);
    localparam int CW = $clog2(N_BITS + 1);
    localparam logic [CW-1:0] LP_N = CW'(N_BITS);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_sck_sync;
    logic [2:0]        r_cs_sync;
    logic [1:0]        r_mosi_sync;
    logic [CW-1:0]     r_bit_cnt;
    logic [N_BITS-1:0] r_tx_shift;
    logic [N_BITS-1:0] r_rx_shift;

    logic              w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
    logic [CW-1:0]     w_cnt_inc;
    logic [N_BITS-1:0] w_rx_nxt;
    logic              w_load, w_cap, w_done, w_shift_out, w_to_idle, w_ferr;

    // Stage [1] is the synchronized level; stage [2] is the previous level for edge detect.
    assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
    assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];
    assign w_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_cs_fall  = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_cnt_inc  = r_bit_cnt + CW'(1);
    assign w_rx_nxt   = {r_rx_shift[N_BITS-2:0], r_mosi_sync[1]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sck_sync  <= 3'b000;
            r_cs_sync   <= 3'b111;
            r_mosi_sync <= 2'b00;
            r_state     <= ST_IDLE;
        end else begin
            r_sck_sync  <= {r_sck_sync[1:0], sck_i};
            r_cs_sync   <= {r_cs_sync[1:0], cs_i};
            r_mosi_sync <= {r_mosi_sync[0], mosi_i};
            r_state     <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_cap       = 1'b0;
        w_done      = 1'b0;
        w_shift_out = 1'b0;
        w_to_idle   = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // CS rise takes priority over a coincident SCK rise, which is then not counted.
                if (w_cs_rise) begin
                    w_to_idle   = 1'b1;
                    w_ferr      = (r_bit_cnt != '0);
                    w_state_nxt = ST_IDLE;
                end else if (w_sck_rise) begin
                    w_cap = 1'b1;
                    if (w_cnt_inc == LP_N) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end else if (w_sck_fall) begin
                    w_shift_out = 1'b1;
                end
            end
            ST_DONE: begin
                if (w_cs_rise) begin
                    w_to_idle   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_bit_cnt   <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
            busy_o      <= 1'b0;
            miso_o      <= IDLE_MISO;
        end else begin
            rx_valid_o  <= 1'b0;
            frame_err_o <= w_ferr;
            if (w_load) begin
                r_tx_shift <= tx_data_i;
                miso_o     <= tx_data_i[N_BITS-1];
                r_bit_cnt  <= '0;
                busy_o     <= 1'b1;
            end
            if (w_cap) begin
                r_rx_shift <= w_rx_nxt;
                r_bit_cnt  <= w_cnt_inc;
            end
            if (w_done) begin
                rx_data_o  <= w_rx_nxt;
                rx_valid_o <= 1'b1;
                miso_o     <= IDLE_MISO;
            end
            if (w_shift_out) begin
                r_tx_shift <= {r_tx_shift[N_BITS-2:0], 1'b0};
                miso_o     <= r_tx_shift[N_BITS-2];
            end
            if (w_to_idle) begin
                miso_o    <= IDLE_MISO;
                busy_o    <= 1'b0;
                r_bit_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed + randomized SPI master driving spi_slave_responder, checked against a frame-level model.
`timescale 1ns/1ps
module tb_spi_slave_responder;
    localparam logic IDLE = 1'b1;
    localparam int   HALF = 5;

    logic        clk_i     = 1'b0;
    logic        rst_i     = 1'b0;
    logic        sck_i     = 1'b0;
    logic        cs_i      = 1'b1;
    logic        mosi_i    = 1'b0;
    logic [15:0] tx_data_i = '0;
    logic        miso_o;
    logic [15:0] rx_data_o;
    logic        rx_valid_o;
    logic        busy_o;
    logic        frame_err_o;

    int tests = 0;
    int fails = 0;
    int vld_cnt = 0;
    int err_cnt = 0;
    int gap = 6;
    logic [15:0] model_rx = '0;

    spi_slave_responder #(.N_BITS(16), .IDLE_MISO(IDLE)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sck_i      (sck_i),
        .cs_i       (cs_i),
        .mosi_i     (mosi_i),
        .tx_data_i  (tx_data_i),
        .miso_o     (miso_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .busy_o     (busy_o),
        .frame_err_o(frame_err_o)
    );

    always #50 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rx_valid_o === 1'b1) vld_cnt++;
        if (frame_err_o === 1'b1) err_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_i);
        #10;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mode-0 master: MOSI set before each rise, MISO sampled just before the rise.
    task automatic xfer(input logic [15:0] tx, input logic [15:0] mo, input int nclk,
                        input bit simul, output logic [15:0] got, output int idle_bad);
        got = '0;
        idle_bad = 0;
        tx_data_i = tx;
        cs_i = 1'b0;
        wait_clk(6);
        tx_data_i = 16'($urandom);
        check("busy_mid", busy_o, 1);
        for (int i = 0; i < nclk; i++) begin
            mosi_i = (i < 16) ? mo[15-i] : 1'($urandom);
            wait_clk(HALF);
            if (i < 16) got[15-i] = miso_o;
            else if (miso_o !== IDLE) idle_bad++;
            if (simul && i == nclk - 1) begin
                sck_i = 1'b1;
                cs_i  = 1'b1;
                wait_clk(HALF);
                sck_i = 1'b0;
                wait_clk(gap);
                return;
            end
            sck_i = 1'b1;
            wait_clk(HALF);
            sck_i = 1'b0;
        end
        wait_clk(HALF);
        cs_i = 1'b1;
        wait_clk(gap);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] tx, input logic [15:0] mo,
                             input int nclk, input bit simul);
        int          v0, e0, ib, counted, k;
        bit          full;
        logic [15:0] gm, mask, exp_rx;
        v0 = vld_cnt;
        e0 = err_cnt;
        xfer(tx, mo, nclk, simul, gm, ib);
        counted = simul ? nclk - 1 : nclk;
        full    = (counted >= 16);
        exp_rx  = full ? mo : model_rx;
        k       = (nclk < 16) ? nclk : 16;
        mask    = 16'hFFFF;
        mask    = (k >= 16) ? mask : ~(mask >> k);
        check({tag, "_miso_word"}, gm & mask, tx & mask);
        check({tag, "_rx_valid_pulses"}, vld_cnt - v0, full ? 1 : 0);
        check({tag, "_frame_err_pulses"}, err_cnt - e0, (counted > 0 && !full) ? 1 : 0);
        check({tag, "_rx_data"}, rx_data_o, exp_rx);
        check({tag, "_busy_after"}, busy_o, 0);
        check({tag, "_miso_after"}, miso_o, IDLE);
        if (nclk > 16) check({tag, "_miso_idle_extra"}, ib, 0);
        model_rx = exp_rx;
    endtask

    initial begin
        int v0, e0, n;
        bit s;
        wait_clk(3);
        check("rst_miso", miso_o, IDLE);
        check("rst_rx_data", rx_data_o, 0);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_frame_err", frame_err_o, 0);
        rst_i = 1'b1;
        wait_clk(5);

        run_frame("t1", 16'hA5C3, 16'h3C5A, 16, 1'b0);
        run_frame("t2_abort7", 16'h1234, 16'hBEEF, 7, 1'b0);
        run_frame("t3_20clk", 16'h8001, 16'hC0DE, 20, 1'b0);

        // Reset mid-frame after 9 bits must act without a clock edge.
        tx_data_i = 16'hFFFF;
        cs_i = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 9; i++) begin
            mosi_i = 1'b1;
            wait_clk(HALF);
            sck_i = 1'b1;
            wait_clk(HALF);
            sck_i = 1'b0;
        end
        wait_clk(2);
        rst_i = 1'b0;
        #1;
        check("t4_rst_miso", miso_o, IDLE);
        check("t4_rst_rx_data", rx_data_o, 0);
        check("t4_rst_busy", busy_o, 0);
        check("t4_rst_rx_valid", rx_valid_o, 0);
        check("t4_rst_frame_err", frame_err_o, 0);
        wait_clk(2);
        cs_i = 1'b1;
        wait_clk(2);
        rst_i = 1'b1;
        model_rx = '0;
        wait_clk(5);
        run_frame("t4_after", 16'h5A5A, 16'h9C31, 16, 1'b0);

        gap = 4;
        run_frame("t5_a", 16'h7E00, 16'h0001, 16, 1'b0);
        run_frame("t5_b", 16'h81FF, 16'hFFFF, 16, 1'b0);
        gap = 6;

        v0 = vld_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 10; i++) begin
            sck_i = ~sck_i;
            mosi_i = 1'($urandom);
            wait_clk(3);
            check("t6_busy", busy_o, 0);
            check("t6_miso", miso_o, IDLE);
        end
        sck_i = 1'b0;
        wait_clk(4);
        check("t6_no_valid", vld_cnt - v0, 0);
        check("t6_no_err", err_cnt - e0, 0);

        run_frame("simul16", 16'hF00F, 16'h1357, 16, 1'b1);
        run_frame("simul8", 16'h0FF0, 16'h2468, 8, 1'b1);

        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(1, 20);
            s = 1'($urandom);
            run_frame("rand", 16'($urandom), 16'($urandom), n, s);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
